// File: rtl/gpio_bank_ctrl.sv
// Register-mapped GPIO bank: per-pin software/alternate-function output select,
// synchronised inputs with edge-triggered, maskable, sticky interrupt status.
module gpio_bank_ctrl #(
  parameter int NUM_PINS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bus_valid,
  input  logic                bus_we,
  input  logic [2:0]          bus_addr,
  input  logic [NUM_PINS-1:0] bus_wdata,
  output logic [NUM_PINS-1:0] bus_rdata,
  output logic                bus_ready,
  input  logic [NUM_PINS-1:0] pin_in,
  input  logic [NUM_PINS-1:0] alt_out,
  output logic [NUM_PINS-1:0] pin_out,
  output logic                irq
);

  localparam logic [2:0] A_DOUT     = 3'd0;
  localparam logic [2:0] A_OSEL     = 3'd1;
  localparam logic [2:0] A_DIN      = 3'd2;
  localparam logic [2:0] A_IRQ_EN   = 3'd3;
  localparam logic [2:0] A_IRQ_POL  = 3'd4;
  localparam logic [2:0] A_IRQ_STAT = 3'd5;
  localparam logic [2:0] A_DOUT_TGL = 3'd6;

  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int CW         = $clog2(ARM_CYCLES + 1);

  logic [NUM_PINS-1:0] r_dout;
  logic [NUM_PINS-1:0] r_osel;
  logic [NUM_PINS-1:0] r_irq_en;
  logic [NUM_PINS-1:0] r_irq_pol;
  logic [NUM_PINS-1:0] r_irq_stat;
  logic [NUM_PINS-1:0] r_sync [SYNC_STAGES];
  logic [NUM_PINS-1:0] r_prev;
  logic [CW-1:0]       r_arm_cnt;
  logic                r_ready;
  logic [NUM_PINS-1:0] r_rdata;

  logic                w_accept;
  logic                w_armed;
  logic [NUM_PINS-1:0] w_din;
  logic [NUM_PINS-1:0] w_rise;
  logic [NUM_PINS-1:0] w_fall;
  logic [NUM_PINS-1:0] w_edge_sel;
  logic [NUM_PINS-1:0] w_clr;
  logic [NUM_PINS-1:0] w_rd_val;

  // Handshake: a request is taken on any edge with bus_valid=1 while bus_ready=0;
  // bus_ready is then high for exactly one cycle carrying the read data captured
  // at the accept edge (0 for writes). Holding bus_valid through the ready cycle
  // does not re-accept, so throughput is at most one transaction per two cycles.
  assign w_accept = bus_valid && !r_ready;

  assign w_din      = r_sync[SYNC_STAGES-1];
  assign w_rise     = w_din & ~r_prev;
  assign w_fall     = ~w_din & r_prev;
  assign w_edge_sel = (r_irq_pol & w_fall) | (~r_irq_pol & w_rise);
  assign w_armed    = (r_arm_cnt == CW'(ARM_CYCLES));
  assign w_clr      = (w_accept && bus_we && bus_addr == A_IRQ_STAT) ? bus_wdata : '0;

  always_comb begin
    w_rd_val = '0;
    case (bus_addr)
      A_DOUT:     w_rd_val = r_dout;
      A_OSEL:     w_rd_val = r_osel;
      A_DIN:      w_rd_val = w_din;
      A_IRQ_EN:   w_rd_val = r_irq_en;
      A_IRQ_POL:  w_rd_val = r_irq_pol;
      A_IRQ_STAT: w_rd_val = r_irq_stat;
      default:    w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_accept;
      r_rdata <= (w_accept && !bus_we) ? w_rd_val : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout    <= '0;
      r_osel    <= '0;
      r_irq_en  <= '0;
      r_irq_pol <= '0;
    end else if (w_accept && bus_we) begin
      case (bus_addr)
        A_DOUT:     r_dout    <= bus_wdata;
        A_OSEL:     r_osel    <= bus_wdata;
        A_IRQ_EN:   r_irq_en  <= bus_wdata;
        A_IRQ_POL:  r_irq_pol <= bus_wdata;
        A_DOUT_TGL: r_dout    <= r_dout ^ bus_wdata;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= pin_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_din;
    end
  end

  // Edges are ignored until pad levels present at reset have flushed through
  // the synchroniser and the prev register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arm_cnt  <= '0;
      r_irq_stat <= '0;
    end else begin
      if (!w_armed) r_arm_cnt <= r_arm_cnt + 1'b1;
      r_irq_stat <= (r_irq_stat & ~w_clr) | (w_armed ? w_edge_sel : '0);
    end
  end

  assign pin_out   = (r_dout & r_osel) | (alt_out & ~r_osel);
  assign irq       = |(r_irq_stat & r_irq_en);
  assign bus_ready = r_ready;
  assign bus_rdata = r_rdata;

endmodule
